// File: rtl/sad_accumulator.sv
// Streaming sum-of-absolute-differences over BLOCK_LEN byte pairs, result on a held valid/ready output.
// Optional macro SAD_SATURATE_EN: accumulator clamps at all-ones and raises sticky out_ovf.
module sad_accumulator #(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sad,
    output logic              out_ovf,
    output logic              busy
);
    // state | meaning
    // IDLE  | first cycle out of reset, not yet accepting
    // ACC   | accepting pairs, diffs flowing into the accumulator
    // DRAIN | last accepted diff entering the accumulator
    // DONE  | block result presented until consumed
    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              pipe_v_q;
    logic              out_valid_q;
    logic              ovf_q;
    logic              ovf_d;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] diff_q;
    logic [DATA_W-1:0] diff_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  out_sad_q;
    logic              accept;

    assign accept = in_valid && in_ready_q;
    assign diff_d = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);

`ifdef SAD_SATURATE_EN
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = {1'b0, acc_q} + SUM_W'(diff_q);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (pipe_v_q) begin
            if (sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        ovf_d = 1'b0;
        if (pipe_v_q) begin
            acc_d = acc_q + ACC_W'(diff_q);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            pipe_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            diff_q      <= '0;
            acc_q       <= '0;
            out_sad_q   <= '0;
        end else begin
            pipe_v_q <= accept;
            if (accept) begin
                diff_q <= diff_d;
            end
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            case (state_q)
                IDLE: begin
                    state_q    <= ACC;
                    in_ready_q <= 1'b1;
                end
                ACC: begin
                    if (accept) begin
                        if (count_q == CNT_W'(BLOCK_LEN - 1)) begin
                            count_q    <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                end
                DONE: begin
                    // First DONE cycle latches the settled accumulator; later cycles wait for the consumer.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_sad_q   <= acc_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= ACC;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sad   = out_sad_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q == DRAIN) || (state_q == DONE) || (count_q != '0) || pipe_v_q;
endmodule

// File: tb/tb_sad_accumulator.sv
// Scoreboard bench for sad_accumulator: three instances (block of 4, narrow block of 2, default 16).
// Expected narrow-block result depends on SAD_SATURATE_EN.
module tb_sad_accumulator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic [2:0]  vld  = 3'b000;
    logic [2:0]  ordy = 3'b111;
    logic [2:0]  rdy, ov, ovf, bsy;
    logic [11:0] sad0, sad2;
    logic [7:0]  sad1;
    logic [11:0] sadv [3];

    always_comb begin
        sadv[0] = sad0;
        sadv[1] = {4'h0, sad1};
        sadv[2] = sad2;
    end

    sad_accumulator #(.DATA_W(8), .BLOCK_LEN(4), .ACC_W(12)) u_blk4 (
        .clock(clock), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sad(sad0), .out_ovf(ovf[0]), .busy(bsy[0]));

    sad_accumulator #(.DATA_W(8), .BLOCK_LEN(2), .ACC_W(8)) u_blk2 (
        .clock(clock), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sad(sad1), .out_ovf(ovf[1]), .busy(bsy[1]));

    sad_accumulator #(.DATA_W(8), .BLOCK_LEN(16), .ACC_W(12)) u_blk16 (
        .clock(clock), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sad(sad2), .out_ovf(ovf[2]), .busy(bsy[2]));

    typedef struct {
        int dut;
        int sad;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [2:0] prev_hold = 3'b000;
    int   prev_sad [3];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic expect_result(input int k, input int s, input int o);
        exp_t e;
        e.dut = k;
        e.sad = s;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds the pair on the bus until the DUT takes it; in_ready is stable between edges.
    task automatic send(input int k, input int a, input int b);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_a   = 8'(a);
        in_b   = 8'(b);
        vld[k] = 1'b1;
        while (!ok && n < 50) begin
            ok = rdy[k];
            tick();
            n++;
        end
        vld[k] = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout dut%0d: in_ready got 0 required 1", k);
        end
    endtask

    task automatic wait_result(input int k);
        int n;
        n = 0;
        while (!ov[k] && n < 40) begin
            tick();
            n++;
        end
        if (!ov[k]) begin
            n_checks++;
            n_err++;
            $display("FAIL result_timeout dut%0d: out_valid got 0 required 1", k);
        end else begin
            tick();
        end
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset && ov[k]) begin
                if (prev_hold[k]) begin
                    chk($sformatf("hold_sad_dut%0d", k), int'(sadv[k]), prev_sad[k]);
                end
                if (ordy[k]) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_result dut%0d: got sad %0d required no result", k, sadv[k]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk($sformatf("sb_dut%0d", k), k, mon_e.dut);
                        chk($sformatf("sb_sad_dut%0d", k), int'(sadv[k]), mon_e.sad);
                        chk($sformatf("sb_ovf_dut%0d", k), int'(ovf[k]), mon_e.ovf);
                    end
                end
            end
            prev_hold[k] = !reset && ov[k] && !ordy[k];
            prev_sad[k]  = int'(sadv[k]);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready_dut%0d", k), int'(rdy[k]), 0);
            chk($sformatf("rst_out_valid_dut%0d", k), int'(ov[k]), 0);
            chk($sformatf("rst_out_sad_dut%0d", k), int'(sadv[k]), 0);
            chk($sformatf("rst_out_ovf_dut%0d", k), int'(ovf[k]), 0);
            chk($sformatf("rst_busy_dut%0d", k), int'(bsy[k]), 0);
        end
        reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("idle_to_acc_in_ready_dut%0d", k), int'(rdy[k]), 1);
        end

        // Back-to-back block, latency and single-cycle result pulse.
        expect_result(0, 269, 0);
        send(0, 10, 3);
        send(0, 3, 10);
        send(0, 255, 0);
        chk("t1_busy_mid", int'(bsy[0]), 1);
        send(0, 0, 0);
        chk("t1_valid_n0", int'(ov[0]), 0);
        chk("t1_in_ready_low", int'(rdy[0]), 0);
        tick();
        chk("t1_valid_n1", int'(ov[0]), 0);
        tick();
        chk("t1_valid_n2", int'(ov[0]), 1);
        tick();
        chk("t1_pulse_end", int'(ov[0]), 0);
        chk("t1_in_ready_back", int'(rdy[0]), 1);
        chk("t1_busy_idle", int'(bsy[0]), 0);

        // Idle gap between pairs 2 and 3.
        expect_result(0, 269, 0);
        send(0, 10, 3);
        send(0, 3, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_gap_in_ready", int'(rdy[0]), 1);
            chk("t2_gap_busy", int'(bsy[0]), 1);
        end
        send(0, 255, 0);
        send(0, 0, 0);
        chk("t2_valid_n0", int'(ov[0]), 0);
        tick();
        tick();
        chk("t2_valid_n2", int'(ov[0]), 1);
        tick();

        // Result held under backpressure while a pair waits on the input.
        ordy[0] = 1'b0;
        expect_result(0, 269, 0);
        expect_result(0, 8, 0);
        send(0, 10, 3);
        send(0, 3, 10);
        send(0, 255, 0);
        send(0, 0, 0);
        in_a   = 8'd9;
        in_b   = 8'd1;
        vld[0] = 1'b1;
        n = 0;
        while (!ov[0] && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", int'(ov[0]), 1);
            chk("t3_hold_sad", int'(sad0), 269);
            chk("t3_hold_in_ready", int'(rdy[0]), 0);
        end
        ordy[0] = 1'b1;
        send(0, 9, 1);
        send(0, 0, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        wait_result(0);

        // Reset mid-block discards the partial block.
        send(0, 5, 1);
        send(0, 7, 2);
        reset = 1'b1;
        tick();
        chk("t4_rst_in_ready", int'(rdy[0]), 0);
        chk("t4_rst_out_valid", int'(ov[0]), 0);
        chk("t4_rst_out_sad", int'(sad0), 0);
        chk("t4_rst_out_ovf", int'(ovf[0]), 0);
        chk("t4_rst_busy", int'(bsy[0]), 0);
        reset = 1'b0;
        tick();
        chk("t4_in_ready_after", int'(rdy[0]), 1);
        expect_result(0, 4, 0);
        for (int i = 0; i < 4; i++) send(0, 1, 2);
        wait_result(0);

        // Narrow accumulator: wrap or saturate.
`ifdef SAD_SATURATE_EN
        expect_result(1, 255, 1);
`else
        expect_result(1, 144, 0);
`endif
        send(1, 200, 0);
        send(1, 200, 0);
        wait_result(1);

        // Default parameters: equal operands and full-scale differences.
        expect_result(2, 0, 0);
        for (int i = 0; i < 16; i++) send(2, 77, 77);
        wait_result(2);
        expect_result(2, 4080, 0);
        for (int i = 0; i < 16; i++) send(2, 0, 255);
        wait_result(2);

        for (int i = 0; i < 5; i++) tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sad_accumulator.md
Name: sad_accumulator

Overview:
Streaming sum-of-absolute-differences stage directly downstream of the 8-bit operand adder path. Accepts one (a, b) byte pair per cycle over a valid/ready handshake and forms |a-b| in a registered pipeline stage. Accumulates BLOCK_LEN differences and presents the block SAD on a valid/ready output that holds until it is consumed.

Parameters:
DATA_W, 8, operand width in bits
BLOCK_LEN, 16, samples per block; must be >= 2
ACC_W, 12, accumulator/result width; must be >= DATA_W + clog2(BLOCK_LEN) for wrap-free operation

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input pair valid
in_ready  output  1  stage can accept a pair (registered)
in_a  input  DATA_W  operand a, unsigned
in_b  input  DATA_W  operand b, unsigned
out_valid  output  1  block result valid
out_ready  input  1  downstream accepts result
out_sad  output  ACC_W  block SAD, unsigned
out_ovf  output  1  accumulator overflowed this block (SAD_SATURATE_EN only)
busy  output  1  block in progress (count != 0, pipe non-empty, or result pending)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset, sampled at posedge, has priority over everything, including mid-block: state=IDLE, in_ready=0, out_valid=0, out_sad=0, out_ovf=0, busy=0; accumulator, count and diff pipe cleared; partial block discarded.
- FSM IDLE -> ACC: unconditional on the first clock after reset deasserts; in_ready=1 from that cycle.
- ACC:
  - Accept on in_valid & in_ready; gaps in in_valid allowed and do not advance the count.
  - Accepted pair registered as diff = (a>=b) ? a-b : b-a, DATA_W bits, with a pipe-valid bit.
  - Next cycle, a valid diff is added to the accumulator, zero-extended to ACC_W.
  - count increments per accepted pair (width clog2(BLOCK_LEN)).
  - When the accepted pair has count==BLOCK_LEN-1: count -> 0, in_ready -> 0, state -> DRAIN.
- DRAIN: one cycle; last diff enters the accumulator; state -> DONE.
- DONE:
  - out_valid=1; out_sad = final accumulator; both held stable while out_ready=0.
  - in_ready=0, so in_valid is ignored.
  - On out_valid & out_ready: out_valid -> 0, accumulator -> 0, out_ovf -> 0, state -> ACC, in_ready -> 1 the next cycle.
  - A pair presented in the handshake cycle is not accepted.
- Latency: final pair accepted at edge N -> out_valid=1 after edge N+2. Max throughput is BLOCK_LEN pairs per BLOCK_LEN+3 cycles with out_ready tied high.
- out_sad between results holds the last delivered value (0 after reset); it is meaningful only while out_valid=1.
- Arithmetic is unsigned throughout; no signed interpretation of inputs.

Optional Feature:
- Macro SAD_SATURATE_EN.
- Defined: an accumulator add whose true sum exceeds 2^ACC_W-1 clamps to 2^ACC_W-1 and sets sticky out_ovf, which remains set through DONE and clears on the result handshake or reset.
- Undefined: the accumulator wraps modulo 2^ACC_W and out_ovf is tied to 0.

Test Plan:
- BLOCK_LEN=4, ACC_W=12, out_ready=1; back-to-back pairs (10,3),(3,10),(255,0),(0,0) -> out_valid high exactly 2 cycles after the 4th accept, out_sad=269, one-cycle pulse, in_ready back to 1 the cycle after.
- Same block with in_valid dropped for 3 cycles between pairs 2 and 3 -> out_sad=269; count unaffected by idle cycles.
- out_ready=0 for 5 cycles in DONE while in_valid=1 with pair (9,1) -> out_sad holds 269, in_ready=0, pair not consumed; after out_ready=1 the next block starts from acc 0 with (9,1) as its first sample.
- reset pulsed for 1 cycle after 2 of 4 pairs -> all outputs 0 that cycle; next full block (1,2)x4 gives out_sad=4, with no residue from the aborted block.
- ACC_W=8, BLOCK_LEN=2, pairs (200,0),(200,0): with SAD_SATURATE_EN -> out_sad=255, out_ovf=1; without -> out_sad=144, out_ovf=0.
- Equal operands (77,77)x16 at default parameters -> out_sad=0; operands (0,255)x16 -> out_sad=4080 with no overflow.
